mult_array_scheduler: RTL and testbench

Sequences the multiplier array plus coordinate-computation datapath through one layer's Cartesian product of weight vectors against input-activation vectors. Weight vectors are the outer loop and activation vectors the inner loop. The block:
- issues one (weight, activation) pair per cycle to the buffer read ports,
- generates the `decode_restart` and `Layer_change_flag` controls,
- holds issue under crossbar backpressure,
- drains the array pipeline, then reports completion.

It sits between the layer-level controller and the multiplier/coordinate stage.

---
 rtl/mult_array_scheduler_pkg.sv | 26 ++
 rtl/mult_array_scheduler_pair_counter.sv | 43 ++++
 rtl/mult_array_scheduler.sv | 153 +++++++++++++++
 tb/tb_mult_array_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_array_scheduler_pkg.sv
// Shared types and default sizing for the multiplier-array pass scheduler.
package mult_array_scheduler_pkg;

  localparam int CNT_W     = 8;
  localparam int IA_ADDR_W = 10;
  localparam int W_ADDR_W  = 10;
  localparam int MULT_LAT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAYER,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic [CNT_W-1:0]     num_ia;
    logic [CNT_W-1:0]     num_w;
    logic [IA_ADDR_W-1:0] ia_base;
    logic [W_ADDR_W-1:0]  w_base;
    logic                 sparse;
    logic                 layer_change;
  } sched_cfg_t;

endpackage

// File: rtl/mult_array_scheduler_pair_counter.sv
// Nested activation/weight counter: activation index is the inner loop.
module pair_counter #(
  parameter int CNT_W = mult_array_scheduler_pkg::CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_adv,
  input  logic [CNT_W-1:0]     i_num_ia,
  input  logic [CNT_W-1:0]     i_num_w,
  output logic                 o_ia_zero,
  output logic                 o_ia_wrap,
  output logic                 o_last,
  output logic [2*CNT_W-1:0]   o_pair_cnt
);
  import mult_array_scheduler_pkg::*;

  logic [CNT_W-1:0]   r_ia_cnt;
  logic [CNT_W-1:0]   r_w_cnt;
  logic [2*CNT_W-1:0] r_pair_cnt;

  assign o_ia_zero  = (r_ia_cnt == '0);
  assign o_ia_wrap  = (r_ia_cnt == i_num_ia - CNT_W'(1));
  assign o_last     = o_ia_wrap && (r_w_cnt == i_num_w - CNT_W'(1));
  assign o_pair_cnt = r_pair_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ia_cnt   <= '0;
      r_w_cnt    <= '0;
      r_pair_cnt <= '0;
    end else if (i_adv) begin
      r_pair_cnt <= r_pair_cnt + (2*CNT_W)'(1);
      if (o_ia_wrap) begin
        r_ia_cnt <= '0;
        r_w_cnt  <= r_w_cnt + CNT_W'(1);
      end else begin
        r_ia_cnt <= r_ia_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mult_array_scheduler.sv
// Sequences one layer's weight x activation sweep through the multiplier array.
// state | meaning
// IDLE  | waiting for start
// LAYER | one-cycle layer-change pulse before issue
// ISSUE | one pair per cycle when buffers ready and crossbar not stalled
// DRAIN | waiting MULT_LAT unstalled cycles for the pipeline to empty
// DONE  | one-cycle completion pulse
module mult_array_scheduler #(
  parameter int CNT_W     = mult_array_scheduler_pkg::CNT_W,
  parameter int IA_ADDR_W = mult_array_scheduler_pkg::IA_ADDR_W,
  parameter int W_ADDR_W  = mult_array_scheduler_pkg::W_ADDR_W,
  parameter int MULT_LAT  = mult_array_scheduler_pkg::MULT_LAT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_layer_change,
  input  logic                 i_sparse,
  input  logic [CNT_W-1:0]     i_num_ia_vec,
  input  logic [CNT_W-1:0]     i_num_w_vec,
  input  logic [IA_ADDR_W-1:0] i_ia_base_addr,
  input  logic [W_ADDR_W-1:0]  i_w_base_addr,
  input  logic                 i_ia_rdy,
  input  logic                 i_w_rdy,
  input  logic                 i_xbar_stall,
  output logic                 o_ia_rd_en,
  output logic [IA_ADDR_W-1:0] o_ia_rd_addr,
  output logic                 o_w_rd_en,
  output logic [W_ADDR_W-1:0]  o_w_rd_addr,
  output logic                 o_issue,
  output logic                 o_decode_restart,
  output logic                 o_layer_change_flag,
  output logic                 o_sparse_q,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*CNT_W-1:0]   o_pair_cnt
);
  import mult_array_scheduler_pkg::*;

  sched_state_t         r_state;
  sched_cfg_t           r_cfg;
  logic [CNT_W-1:0]     r_drain;
  logic [IA_ADDR_W-1:0] r_ia_addr;
  logic [W_ADDR_W-1:0]  r_w_addr;
  logic                 r_lc_flag;
  logic                 r_done;
  logic                 r_busy;

  logic w_issue;
  logic w_ia_zero;
  logic w_ia_wrap;
  logic w_last;
  logic w_launch;
  logic w_unused_cfg;

  // Layer-change request and weight base only matter at launch; kept latched for debug.
  assign w_unused_cfg = r_cfg.layer_change | (|r_cfg.w_base);

  assign w_launch = (r_state == ST_IDLE) && i_start;
  assign w_issue  = (r_state == ST_ISSUE) && i_ia_rdy && i_w_rdy && !i_xbar_stall;

  pair_counter #(.CNT_W(CNT_W)) u_pair_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_launch),
    .i_adv      (w_issue),
    .i_num_ia   (r_cfg.num_ia),
    .i_num_w    (r_cfg.num_w),
    .o_ia_zero  (w_ia_zero),
    .o_ia_wrap  (w_ia_wrap),
    .o_last     (w_last),
    .o_pair_cnt (o_pair_cnt)
  );

  assign o_issue             = w_issue;
  assign o_ia_rd_en          = w_issue;
  assign o_w_rd_en           = w_issue && w_ia_zero;
  assign o_decode_restart    = w_issue && w_ia_zero;
  assign o_ia_rd_addr        = r_ia_addr;
  assign o_w_rd_addr         = r_w_addr;
  assign o_layer_change_flag = r_lc_flag;
  assign o_done              = r_done;
  assign o_busy              = r_busy;
  assign o_sparse_q          = r_cfg.sparse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cfg     <= '0;
      r_drain   <= '0;
      r_ia_addr <= '0;
      r_w_addr  <= '0;
      r_lc_flag <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_lc_flag <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cfg     <= '{num_ia: i_num_ia_vec, num_w: i_num_w_vec,
                           ia_base: i_ia_base_addr, w_base: i_w_base_addr,
                           sparse: i_sparse, layer_change: i_layer_change};
            r_ia_addr <= i_ia_base_addr;
            r_w_addr  <= i_w_base_addr;
            r_busy    <= 1'b1;
            if (i_num_ia_vec == '0 || i_num_w_vec == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (i_layer_change) begin
              r_state   <= ST_LAYER;
              r_lc_flag <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_LAYER: r_state <= ST_ISSUE;
        ST_ISSUE: begin
          if (w_issue) begin
            // Addresses track the counters one step ahead so they are registered.
            if (w_ia_wrap) begin
              r_ia_addr <= r_cfg.ia_base;
              r_w_addr  <= r_w_addr + W_ADDR_W'(1);
            end else begin
              r_ia_addr <= r_ia_addr + IA_ADDR_W'(1);
            end
            if (w_last) begin
              r_state <= ST_DRAIN;
              r_drain <= CNT_W'(MULT_LAT);
            end
          end
        end
        ST_DRAIN: begin
          if (!i_xbar_stall) begin
            r_drain <= r_drain - CNT_W'(1);
            if (r_drain == CNT_W'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_array_scheduler.sv
// Self-checking bench: queue-based pass model checked every cycle, plus directed literal checks.
module tb_mult_array_scheduler;

  localparam int LAT = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       lc;
  logic       sp;
  logic [7:0] nia;
  logic [7:0] nw;
  logic [9:0] iab;
  logic [9:0] wb;
  logic       ia_rdy;
  logic       w_rdy;
  logic       stall;

  logic        o_ia_rd_en;
  logic [9:0]  o_ia_rd_addr;
  logic        o_w_rd_en;
  logic [9:0]  o_w_rd_addr;
  logic        o_issue;
  logic        o_decode_restart;
  logic        o_layer_change_flag;
  logic        o_sparse_q;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_pair_cnt;

  mult_array_scheduler #(.CNT_W(8), .IA_ADDR_W(10), .W_ADDR_W(10), .MULT_LAT(LAT)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_start             (start),
    .i_layer_change      (lc),
    .i_sparse            (sp),
    .i_num_ia_vec        (nia),
    .i_num_w_vec         (nw),
    .i_ia_base_addr      (iab),
    .i_w_base_addr       (wb),
    .i_ia_rdy            (ia_rdy),
    .i_w_rdy             (w_rdy),
    .i_xbar_stall        (stall),
    .o_ia_rd_en          (o_ia_rd_en),
    .o_ia_rd_addr        (o_ia_rd_addr),
    .o_w_rd_en           (o_w_rd_en),
    .o_w_rd_addr         (o_w_rd_addr),
    .o_issue             (o_issue),
    .o_decode_restart    (o_decode_restart),
    .o_layer_change_flag (o_layer_change_flag),
    .o_sparse_q          (o_sparse_q),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_pair_cnt          (o_pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: pass phase plus a queue of the (w, ia) pairs still to issue.
  // phase 0 idle, 1 layer pulse, 2 issuing, 3 draining, 4 done pulse
  int         m_phase  = 0;
  int         q_w[$];
  int         q_ia[$];
  logic [9:0] m_iab    = '0;
  logic [9:0] m_wb     = '0;
  logic       m_sparse = 1'b0;
  int         m_pairs  = 0;
  int         m_drain  = 0;

  // Directed observation
  int          cyc = 0;
  logic [63:0] mk_issue, mk_wen, mk_done, mk_lc;
  int          obs_ia[$];
  int          obs_w[$];
  logic        use_plan = 1'b0;
  logic [63:0] stall_plan, ialow_plan;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_issue();
    return (m_phase == 2) && ia_rdy && w_rdy && !stall;
  endfunction

  task automatic compare();
    logic e_iss, e_first;
    e_iss   = m_issue();
    e_first = e_iss && (q_ia[0] == 0);
    chk("issue", o_issue, e_iss);
    chk("ia_rd_en", o_ia_rd_en, e_iss);
    chk("w_rd_en", o_w_rd_en, e_first);
    chk("decode_restart", o_decode_restart, e_first);
    chk("busy", o_busy, m_phase != 0);
    chk("done", o_done, m_phase == 4);
    chk("layer_change_flag", o_layer_change_flag, m_phase == 1);
    chk("sparse_q", o_sparse_q, m_sparse);
    chk("pair_cnt", {16'b0, o_pair_cnt}, m_pairs);
    if (m_phase == 2) begin
      chk("ia_rd_addr", o_ia_rd_addr, (int'(m_iab) + q_ia[0]) % 1024);
      chk("w_rd_addr", o_w_rd_addr, (int'(m_wb) + q_w[0]) % 1024);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_sparse = 0; m_pairs = 0; m_drain = 0;
      q_w.delete(); q_ia.delete();
      return;
    end
    case (m_phase)
      0: if (start) begin
        m_iab = iab; m_wb = wb; m_sparse = sp; m_pairs = 0;
        q_w.delete(); q_ia.delete();
        for (int w = 0; w < int'(nw); w++)
          for (int a = 0; a < int'(nia); a++) begin
            q_w.push_back(w); q_ia.push_back(a);
          end
        if (q_w.size() == 0) m_phase = 4;
        else m_phase = lc ? 1 : 2;
      end
      1: m_phase = 2;
      2: if (m_issue()) begin
        void'(q_w.pop_front()); void'(q_ia.pop_front());
        m_pairs++;
        if (q_w.size() == 0) begin m_phase = 3; m_drain = LAT; end
      end
      3: if (!stall) begin
        m_drain--;
        if (m_drain == 0) m_phase = 4;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    if (use_plan && cyc < 64) begin
      stall  = stall_plan[cyc];
      ia_rdy = ~ialow_plan[cyc];
    end
    #1;
    compare();
    if (cyc < 64) begin
      mk_issue[cyc] = o_issue;
      mk_wen[cyc]   = o_w_rd_en;
      mk_done[cyc]  = o_done;
      mk_lc[cyc]    = o_layer_change_flag;
    end
    if (o_issue) begin
      obs_ia.push_back(int'(o_ia_rd_addr));
      obs_w.push_back(int'(o_w_rd_addr));
    end
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_pass(input int nia_v, input int nw_v, input logic lc_v,
                            input logic [9:0] iab_v, input logic [9:0] wb_v);
    mk_issue = '0; mk_wen = '0; mk_done = '0; mk_lc = '0;
    obs_ia.delete(); obs_w.delete();
    cyc = 0;
    start = 1; lc = lc_v; sp = 1; nia = 8'(nia_v); nw = 8'(nw_v); iab = iab_v; wb = wb_v;
    step();
    start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1; start = 0; lc = 0; sp = 0; nia = 0; nw = 0; iab = 0; wb = 0;
    ia_rdy = 1; w_rdy = 1; stall = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset issue", o_issue, 0);
    chk("reset pair_cnt", {16'b0, o_pair_cnt}, 0);
    chk("reset ia_rd_addr", o_ia_rd_addr, 0);
    chk("reset w_rd_addr", o_w_rd_addr, 0);
    chk("reset sparse_q", o_sparse_q, 0);
    rst = 0;
    @(negedge clk);

    // 3x2 stall-free pass
    begin_pass(3, 2, 0, 10'd100, 10'd200);
    repeat (12) step();
    chk("t1 issue cycles", mk_issue[31:0], 32'h7E);
    chk("t1 w_rd_en cycles", mk_wen[31:0], 32'h12);
    chk("t1 done cycle", mk_done[31:0], 32'h200);
    chk("t1 pair_cnt", {16'b0, o_pair_cnt}, 6);
    chk("t1 n issued", obs_ia.size(), 6);
    if (obs_ia.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t1 ia addr", obs_ia[k], 100 + (k % 3));
        chk("t1 w addr", obs_w[k], 200 + (k / 3));
      end
    end

    // Same with layer change
    begin_pass(3, 2, 1, 10'd0, 10'd0);
    repeat (12) step();
    chk("t2 lc cycles", mk_lc[31:0], 32'h2);
    chk("t2 issue cycles", mk_issue[31:0], 32'hFC);
    chk("t2 done cycle", mk_done[31:0], 32'h400);

    // Stalls at cycles 3-4, ia_rdy low at 6
    use_plan = 1; stall_plan = 64'h18; ialow_plan = 64'h40;
    begin_pass(3, 2, 0, 10'd5, 10'd7);
    repeat (15) step();
    use_plan = 0; stall = 0; ia_rdy = 1;
    chk("t3 issue cycles", mk_issue[31:0], 32'h3A6);
    chk("t3 done cycle", mk_done[31:0], 32'h1000);
    chk("t3 pair_cnt", {16'b0, o_pair_cnt}, 6);
    chk("t3 n issued", obs_ia.size(), 6);
    if (obs_ia.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("t3 ia addr", obs_ia[k], 5 + (k % 3));
    end

    // Zero weight vectors
    begin_pass(3, 0, 0, 10'd0, 10'd0);
    repeat (4) step();
    chk("t4 done cycle", mk_done[31:0], 32'h2);
    chk("t4 issue none", mk_issue[31:0], 0);
    chk("t4 w_rd_en none", mk_wen[31:0], 0);

    // Address wrap
    begin_pass(4, 1, 0, 10'd1022, 10'd1023);
    repeat (8) step();
    chk("t5 n issued", obs_ia.size(), 4);
    if (obs_ia.size() == 4) begin
      chk("t5 addr0", obs_ia[0], 1022);
      chk("t5 addr1", obs_ia[1], 1023);
      chk("t5 addr2", obs_ia[2], 0);
      chk("t5 addr3", obs_ia[3], 1);
    end

    // Reset mid-pass, then a full pass
    begin_pass(3, 2, 0, 10'd100, 10'd200);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("t6 busy after rst", o_busy, 0);
    chk("t6 pair_cnt after rst", {16'b0, o_pair_cnt}, 0);
    chk("t6 sparse after rst", o_sparse_q, 0);
    chk("t6 ia addr after rst", o_ia_rd_addr, 0);
    chk("t6 w addr after rst", o_w_rd_addr, 0);
    repeat (10) step();
    chk("t6 no done", mk_done[31:0], 0);
    begin_pass(3, 2, 0, 10'd100, 10'd200);
    repeat (12) step();
    chk("t6 rerun done", mk_done[31:0], 32'h200);
    chk("t6 rerun pair_cnt", {16'b0, o_pair_cnt}, 6);

    // Randomised passes with random readiness, stalls and ignored mid-pass starts
    for (int p = 0; p < 40; p++) begin
      begin_pass($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom),
                 10'($urandom), 10'($urandom));
      sp = 1'($urandom);
      budget = 0;
      while (m_phase != 0 && budget < 400) begin
        ia_rdy = ($urandom_range(0, 9) < 8);
        w_rdy  = ($urandom_range(0, 9) < 8);
        stall  = ($urandom_range(0, 9) < 2);
        start  = ($urandom_range(0, 9) == 0);
        if (start) begin
          nia = 8'($urandom); nw = 8'($urandom); lc = 1'($urandom);
          iab = 10'($urandom); wb = 10'($urandom); sp = 1'($urandom);
        end
        step();
        budget++;
      end
      start = 0;
      if (budget >= 400) begin
        n_checks++; n_err++;
        $display("FAIL pass timeout: pass %0d still busy after %0d cycles", p, budget);
      end
      ia_rdy = 1; w_rdy = 1; stall = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
